id_fetch_queue: RTL
===================

ID_FETCH_QUEUE -- requirements
Module: id_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, number of queue entries; power of two, 2..16.
REQ-002 Parameter PC_W, default 32, width of stored PC.
REQ-003 Parameter INST_W, default 32, width of stored instruction word.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  branch/jump redirect; discards all queued entries.
REQ-007 in_valid  input  1  IF presents a fetched {pc, inst} this cycle.
REQ-008 in_pc  input  PC_W  PC of incoming instruction.
REQ-009 in_inst  input  INST_W  incoming instruction word.
REQ-010 in_ready  output  1  queue accepts a push this cycle.
REQ-011 out_valid  output  1  head entry valid for ID.
REQ-012 out_pc  output  PC_W  head entry PC.
REQ-013 out_inst  output  INST_W  head entry instruction.
REQ-014 out_ready  input  1  ID consumes head this cycle (ID not stalled).
REQ-015 count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-016 stallreq  output  1  fetch stall request to stall controller; equals ~in_ready.

Function
REQ-017 Push occurs when in_valid && in_ready; pop occurs when out_valid && out_ready.
REQ-018 Storage SHALL be a circular buffer with write and read pointers of $clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-019 in_ready SHALL be 1 iff count != DEPTH; when full, push is refused even if a pop occurs the same cycle.
REQ-020 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count unchanged and advance both pointers.
REQ-021 Entries SHALL leave in push order; no entry duplicated or lost except by flush or reset.
REQ-022 out_valid SHALL be 1 iff count != 0 (bypass case per REQ-030 aside).
REQ-023 When out_valid is 0, out_pc and out_inst SHALL be driven to 0 (no stale data visible to ID).
REQ-024 Pop with count==0 and no bypass SHALL have no effect; count never underflows.
REQ-025 flush SHALL, at the next edge, set count, read and write pointers to 0; any push or pop in the flush cycle is ignored.
REQ-026 flush has priority over push and pop; rst has priority over flush.
REQ-027 Outputs out_valid/out_pc/out_inst/count SHALL depend only on registered state (plus REQ-030 bypass path).
REQ-028 Minimum push-to-out_valid latency without bypass: 1 cycle.

Reset
REQ-029 On rst high at an edge: count=0, pointers=0, out_valid=0, out_pc=0, out_inst=0, in_ready=1, stallreq=0; storage array contents not reset.

Configuration
REQ-030 Macro ID_FETCH_QUEUE_BYPASS_EN: when defined, with count==0 and no flush, out_valid=in_valid and out_pc/out_inst=in_pc/in_inst combinationally; if out_ready is also 1 the entry is consumed and not stored (count stays 0); if out_ready is 0 it is stored normally.
REQ-031 Without ID_FETCH_QUEUE_BYPASS_EN, no combinational path from in_* to out_*; every entry spends at least one cycle in storage.

Verification
REQ-032 Reset: hold rst 2 cycles -> count=0, out_valid=0, out_pc=0, out_inst=0, in_ready=1.
REQ-033 Fill: DEPTH=4, out_ready=0, push pc 0x00,0x04,0x08,0x0C -> count=4, in_ready=0, stallreq=1; fifth push (pc 0x10) refused; then out_ready=1 -> out_pc 0x00,0x04,0x08,0x0C in order, count returns to 0.
REQ-034 Wrap: 10 back-to-back push/pop pairs at count=2 -> count stays 2, output PC sequence matches input sequence across pointer wrap.
REQ-035 Flush: count=3, assert flush together with push pc 0x40 and out_ready=1 -> next cycle count=0, out_valid=0, pc 0x40 never emitted.
REQ-036 Bypass (macro defined): empty queue, in_valid=1, in_pc=0x100, out_ready=1 -> same cycle out_valid=1, out_pc=0x100; next cycle count=0. Macro undefined: out_valid=0 that cycle, out_pc=0x100 next cycle.
REQ-037 Reset mid-operation: count=3, rst=1 with push and pop asserted -> next cycle all REQ-029 values, no entry emitted afterwards.

Source files
------------

// File: rtl/id_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : id_fetch_queue
// Description : Circular-buffer queue between instruction fetch and decode.
//               Holds {pc, inst} pairs, supports redirect flush, and raises a
//               fetch stall request while full.
//               Optional macro ID_FETCH_QUEUE_BYPASS_EN adds a same-cycle
//               path from the fetch inputs to the decode outputs when empty.
// Revision    : 1.0 - initial release
// ============================================================================
module id_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int PC_W   = 32,
    parameter int INST_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INST_W-1:0]        in_inst,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [PC_W-1:0]          out_pc,
    output logic [INST_W-1:0]        out_inst,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     stallreq
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam int                 c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL  = c_CNT_W'(DEPTH);

    logic [PC_W-1:0]    r_pc_mem   [DEPTH];
    logic [INST_W-1:0]  r_inst_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_empty;
    logic w_bypass;
    logic w_push;
    logic w_store;
    logic w_pop_mem;

    assign w_empty  = (r_count == '0);
    assign in_ready = (r_count != c_FULL);
    assign stallreq = ~in_ready;
    assign count    = r_count;

`ifdef ID_FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards the fetch beat straight to decode; a redirect kills it.
    assign w_bypass = w_empty && !flush && in_valid;
`else
    assign w_bypass = 1'b0;
`endif

    // A bypassed beat that decode takes immediately never enters storage.
    assign w_push    = in_valid && in_ready;
    assign w_store   = w_push && !(w_bypass && out_ready);
    assign w_pop_mem = !w_empty && out_ready;

    // Storage array is data-only and deliberately left unreset.
    always_ff @(posedge clk) begin
        if (w_store && !flush && !rst) begin
            r_pc_mem[r_wr_ptr]   <= in_pc;
            r_inst_mem[r_wr_ptr] <= in_inst;
        end
    end

    // Pointer and occupancy update; reset beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_mem) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_store, w_pop_mem})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head entry to decode; zeros whenever nothing is valid.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = '0;
        out_inst  = '0;
        if (!w_empty) begin
            out_valid = 1'b1;
            out_pc    = r_pc_mem[r_rd_ptr];
            out_inst  = r_inst_mem[r_rd_ptr];
        end else if (w_bypass) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_inst  = in_inst;
        end
    end

endmodule
`default_nettype wire
